// File: rtl/sched_pkg.sv
// Shared cause codes and dispatcher FSM state encodings.
package sched_pkg;

  typedef enum logic [1:0] {
    CauseNone  = 2'b00,
    CauseSys   = 2'b01,
    CauseTimer = 2'b10,
    CauseDma   = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StRedirect = 2'b01,
    StKernel   = 2'b10,
    StReturn   = 2'b11
  } state_e;

endpackage

// File: rtl/irq_pending_latch.sv
// Rising-edge detector on the DMA request feeding a sticky pending bit.
module irq_pending_latch (
  input  logic clock,
  input  logic init_flag,
  input  logic op_int,
  input  logic take,
  output logic pending
);

  logic op_q;
  logic pend_q;
  logic pend_d;

  // A new edge wins over a same-cycle take so that request is not lost.
  always_comb begin
    pend_d = (pend_q & ~take) | (op_int & ~op_q);
  end

  // Edge history and pending bit, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!init_flag) begin
      op_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      op_q   <= op_int;
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;

endmodule

// File: rtl/interrupt_dispatcher.sv
// Interrupt dispatcher: picks syscall/timer/DMA at instruction boundaries, redirects the PC
// into the handler and back on return-from-interrupt.
module interrupt_dispatcher
  import sched_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clock,
  input  logic              init_flag,
  input  logic              timer_int,
  input  logic              op_int,
  input  logic [ADDR_W-1:0] int_pos,
  input  logic [ADDR_W-1:0] dma_int_pos,
  input  logic [ADDR_W-1:0] sys_int_pos,
  input  logic              SYS_ENB,
  input  logic              IRET_ENB,
  input  logic              inst_boundary,
  input  logic [ADDR_W-1:0] pc_next,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              kernel_mode,
  output logic [ADDR_W-1:0] epc,
  output logic [1:0]        int_cause,
  output logic              int_ack
);

  state_e              state_q, state_d;
  cause_e              cause_q, cause_d;
  logic [ADDR_W-1:0]   epc_q, epc_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic                kernel_q, kernel_d;

  cause_e              take_cause;
  logic [ADDR_W-1:0]   take_vec;
  logic                take_dma;
  logic                dma_pending;

  irq_pending_latch u_dma_latch (
    .clock     (clock),
    .init_flag (init_flag),
    .op_int    (op_int),
    .take      (take_dma),
    .pending   (dma_pending)
  );

  // Fixed-priority source select: syscall, then timer, then pending DMA.
  always_comb begin
    take_cause = CauseNone;
    take_vec   = '0;
    if (SYS_ENB) begin
      take_cause = CauseSys;
      take_vec   = sys_int_pos;
    end else if (timer_int) begin
      take_cause = CauseTimer;
      take_vec   = int_pos;
    end else if (dma_pending) begin
      take_cause = CauseDma;
      take_vec   = dma_int_pos;
    end
  end

  assign take_dma = (state_q == StIdle) && inst_boundary && (take_cause == CauseDma);

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    target_d = target_q;
    kernel_d = kernel_q;
    unique case (state_q)
      StIdle: begin
        if (inst_boundary && (take_cause != CauseNone)) begin
          state_d  = StRedirect;
          cause_d  = take_cause;
          epc_d    = pc_next;
          target_d = take_vec;
          kernel_d = 1'b1;
        end
      end
      StRedirect: state_d = StKernel;
      StKernel: begin
        if (inst_boundary && IRET_ENB) begin
          state_d  = StReturn;
          target_d = epc_q;
        end
      end
      StReturn: begin
        state_d  = StIdle;
        cause_d  = CauseNone;
        kernel_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!init_flag) begin
      state_q  <= StIdle;
      cause_q  <= CauseNone;
      epc_q    <= '0;
      target_q <= '0;
      kernel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      target_q <= target_d;
      kernel_q <= kernel_d;
    end
  end

  // Strobes; gating with init_flag aborts a pending redirect/return when reset arrives.
  always_comb begin
    pc_load = init_flag && ((state_q == StRedirect) || (state_q == StReturn));
    int_ack = init_flag && (state_q == StRedirect) && (cause_q == CauseTimer);
  end

  assign pc_target   = target_q;
  assign kernel_mode = kernel_q;
  assign epc         = epc_q;
  assign int_cause   = cause_q;

endmodule

// File: tb/tb_interrupt_dispatcher.sv
module tb_interrupt_dispatcher;

  localparam int unsigned AW = 16;

  logic          clock = 1'b0;
  logic          init_flag = 1'b0;
  logic          timer_int = 1'b0;
  logic          op_int = 1'b0;
  logic [AW-1:0] int_pos = '0;
  logic [AW-1:0] dma_int_pos = '0;
  logic [AW-1:0] sys_int_pos = '0;
  logic          SYS_ENB = 1'b0;
  logic          IRET_ENB = 1'b0;
  logic          inst_boundary = 1'b0;
  logic [AW-1:0] pc_next = '0;
  logic          pc_load;
  logic [AW-1:0] pc_target;
  logic          kernel_mode;
  logic [AW-1:0] epc;
  logic [1:0]    int_cause;
  logic          int_ack;

  interrupt_dispatcher #(.ADDR_W(AW)) dut (
    .clock         (clock),
    .init_flag     (init_flag),
    .timer_int     (timer_int),
    .op_int        (op_int),
    .int_pos       (int_pos),
    .dma_int_pos   (dma_int_pos),
    .sys_int_pos   (sys_int_pos),
    .SYS_ENB       (SYS_ENB),
    .IRET_ENB      (IRET_ENB),
    .inst_boundary (inst_boundary),
    .pc_next       (pc_next),
    .pc_load       (pc_load),
    .pc_target     (pc_target),
    .kernel_mode   (kernel_mode),
    .epc           (epc),
    .int_cause     (int_cause),
    .int_ack       (int_ack)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [AW-1:0] target;
    logic [1:0]  cause;
    logic        ack;
    logic [AW-1:0] epc;
  } load_t;

  typedef struct {
    int   cyc;
    logic k;
  } kexp_t;

  load_t lq[$];
  kexp_t kq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: where the program is (user code / entering / handler / returning),
  // the saved return address, and whether a DMA request is outstanding.
  localparam int User = 0, Entering = 1, Handler = 2, Returning = 3;
  int            m_phase = User;
  bit            m_pend = 0;
  bit            m_op_prev = 0;
  logic [AW-1:0] m_epc = '0;
  logic [1:0]    m_cause = 2'b00;

  logic [AW-1:0] v_int = '0, v_dma = '0, v_sys = '0;

  // Drive one cycle of inputs (sampled at the next rising edge) and predict its effect.
  task automatic step(input bit init, input bit tm, input bit op, input bit sy, input bit ir,
                      input bit bd, input logic [AW-1:0] pcn);
    bit rising;
    bit took_dma;
    logic [1:0] c;
    logic [AW-1:0] v;
    @(posedge clock);
    #1;
    init_flag = init; timer_int = tm; op_int = op; SYS_ENB = sy; IRET_ENB = ir;
    inst_boundary = bd; pc_next = pcn;
    int_pos = v_int; dma_int_pos = v_dma; sys_int_pos = v_sys;
    if (!init) begin
      m_phase = User; m_pend = 0; m_op_prev = 0; m_epc = '0; m_cause = 2'b00;
      lq.delete();
    end else begin
      rising = op && !m_op_prev;
      m_op_prev = op;
      took_dma = 0;
      case (m_phase)
        User: begin
          if (bd && (sy || tm || m_pend)) begin
            if (sy) begin c = 2'b01; v = v_sys; end
            else if (tm) begin c = 2'b10; v = v_int; end
            else begin c = 2'b11; v = v_dma; took_dma = 1; end
            m_epc = pcn; m_cause = c;
            lq.push_back('{cyc: cyc + 1, target: v, cause: c, ack: (c == 2'b10), epc: pcn});
            m_phase = Entering;
          end
        end
        Entering: m_phase = Handler;
        Handler: begin
          if (bd && ir) begin
            lq.push_back('{cyc: cyc + 1, target: m_epc, cause: m_cause, ack: 1'b0, epc: m_epc});
            m_phase = Returning;
          end
        end
        default: begin
          m_phase = User; m_cause = 2'b00;
        end
      endcase
      m_pend = (m_pend && !took_dma) || rising;
    end
    kq.push_back('{cyc: cyc + 1, k: (m_phase != User)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic check_reset_outputs();
    @(negedge clock);
    chk("rst_pc_load", {31'b0, pc_load}, 0);
    chk("rst_pc_target", {16'b0, pc_target}, 0);
    chk("rst_kernel_mode", {31'b0, kernel_mode}, 0);
    chk("rst_epc", {16'b0, epc}, 0);
    chk("rst_int_cause", {30'b0, int_cause}, 0);
    chk("rst_int_ack", {31'b0, int_ack}, 0);
  endtask

  // Monitor: compares each pc_load against the scoreboard, and kernel_mode every cycle.
  bit prev_load = 0;
  always @(negedge clock) begin
    while (lq.size() > 0 && lq[0].cyc < cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL missing_pc_load: got none expected target %0h at cycle %0d",
               lq[0].target, lq[0].cyc);
      void'(lq.pop_front());
    end
    if (pc_load) begin
      chk("pc_load_back_to_back", {31'b0, prev_load}, 0);
      if (lq.size() > 0 && lq[0].cyc == cyc) begin
        load_t e;
        e = lq.pop_front();
        chk("pc_target", {16'b0, pc_target}, {16'b0, e.target});
        chk("int_cause", {30'b0, int_cause}, {30'b0, e.cause});
        chk("int_ack", {31'b0, int_ack}, {31'b0, e.ack});
        chk("epc", {16'b0, epc}, {16'b0, e.epc});
        chk("kernel_on_load", {31'b0, kernel_mode}, 1);
      end else begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_pc_load: got target %0h expected no load (cycle %0d)",
                 pc_target, cyc);
      end
    end else if (int_ack) begin
      n_cmp++; n_bad++;
      $display("FAIL stray_int_ack: got 1 expected 0 (cycle %0d)", cyc);
    end
    while (kq.size() > 0 && kq[0].cyc < cyc) void'(kq.pop_front());
    if (kq.size() > 0 && kq[0].cyc == cyc) begin
      chk("kernel_mode", {31'b0, kernel_mode}, {31'b0, kq[0].k});
      void'(kq.pop_front());
    end
    prev_load = pc_load;
  end

  initial begin
    // Reset
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 0, 16'h0);
    check_reset_outputs();

    // Timer interrupt entry and return
    v_int = 16'h0400; v_dma = 16'h0600; v_sys = 16'h0200;
    step(1, 1, 0, 0, 0, 1, 16'h0123);
    step(1, 0, 0, 0, 0, 0, 16'h0);
    idle(2);
    step(1, 0, 0, 0, 1, 1, 16'h0);
    idle(3);

    // Syscall beats timer and pending DMA; DMA stays pending and is taken later
    step(1, 0, 1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 0, 16'h0);
    step(1, 1, 0, 1, 0, 1, 16'h0777);
    idle(2);
    step(1, 0, 0, 0, 1, 1, 16'h0);
    idle(2);
    step(1, 0, 0, 0, 0, 1, 16'h0888);
    idle(2);
    step(1, 0, 0, 0, 1, 1, 16'h0);
    idle(3);

    // IRET in user mode ignored
    step(1, 0, 0, 0, 1, 1, 16'h0999);
    idle(2);

    // DMA edge during handler; taken at the boundary right after return
    step(1, 0, 0, 1, 0, 1, 16'h0050);
    idle(1);
    step(1, 0, 1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 1, 1, 16'h0);
    step(1, 0, 0, 0, 0, 1, 16'h0060);
    step(1, 0, 0, 0, 0, 1, 16'h0061);
    idle(2);
    step(1, 0, 0, 0, 1, 1, 16'h0);
    idle(3);

    // Timer held without boundary, then boundary
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 0, 16'h0100 + 16'(i));
    step(1, 1, 0, 0, 0, 1, 16'h0200);
    step(1, 0, 0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 1, 1, 16'h0);
    idle(3);

    // Reset while in the handler, then IRET ignored
    step(1, 1, 0, 0, 0, 1, 16'h0321);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 0, 16'h0);
    check_reset_outputs();
    step(1, 0, 0, 0, 1, 1, 16'h0abc);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        v_int = 16'($urandom); v_dma = 16'($urandom); v_sys = 16'($urandom);
      end
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), 16'($urandom));
    end

    // Drain: let the handler return and any outstanding load appear
    step(1, 0, 0, 0, 1, 1, 16'h0);
    idle(2);
    step(1, 0, 0, 0, 1, 1, 16'h0);
    idle(4);
    @(negedge clock);
    #1;
    if (lq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: got %0d loads outstanding expected 0", lq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
